// File: rtl/write_data_router_pkg.sv
// write_data_router_pkg: shared AXI widths, master/slave selectors and the grant entry type
package write_data_router_pkg;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;
    localparam int AXI_LEN_BITS  = 4;
    typedef enum logic [1:0] {M1 = 2'd1, M2 = 2'd2} master_e;
    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, SDEFAULT} slave_e;
    typedef struct packed {
        logic [1:0]              master;
        logic [2:0]              slave;
        logic [AXI_LEN_BITS-1:0] len;
    } grant_t;
    typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/write_data_router_grant_fifo.sv
// grant_fifo: in-order queue of AW grants awaiting their write data
module grant_fifo
    import write_data_router_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  grant_t                       wr_data,
    output grant_t                       rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    grant_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d, wr_en, rd_en;
    // pushes while full are dropped; pops on an empty queue are ignored
    always_comb begin
        wr_en    = push && !full_q;
        rd_en    = pop && (count_q != '0);
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(rd_en);
        full_d   = count_d == CW'(DEPTH);
    end
    // pointer, occupancy and full-flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end
    // entry storage needs no reset: only slots between the pointers are ever read
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = count_q == '0;
endmodule

// File: rtl/write_data_router.sv
// write_data_router: steers granted masters' W beats to decoded slaves in AW order
module write_data_router
    import write_data_router_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int NUM_SLAVES = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     aw_push,
    input  logic [1:0]               aw_master,
    input  logic [2:0]               aw_slave,
    input  logic [AXI_LEN_BITS-1:0]  aw_len,
    output logic                     fifo_full,
    input  logic [AXI_DATA_BITS-1:0] WDATA_M1,
    input  logic [AXI_DATA_BITS-1:0] WDATA_M2,
    input  logic [AXI_STRB_BITS-1:0] WSTRB_M1,
    input  logic [AXI_STRB_BITS-1:0] WSTRB_M2,
    input  logic                     WLAST_M1,
    input  logic                     WLAST_M2,
    input  logic                     WVALID_M1,
    input  logic                     WVALID_M2,
    output logic                     WREADY_M1,
    output logic                     WREADY_M2,
    output logic [AXI_DATA_BITS-1:0] WDATA_S,
    output logic [AXI_STRB_BITS-1:0] WSTRB_S,
    output logic                     WLAST_S,
    output logic [NUM_SLAVES-1:0]    WVALID_S,
    input  logic [NUM_SLAVES-1:0]    WREADY_S,
    output logic                     wdone,
    output logic [1:0]               wdone_master,
    output logic [2:0]               wdone_slave,
    output logic                     last_err
);
    localparam int CW = $clog2(DEPTH + 1);
    grant_t                  head;
    logic [CW-1:0]           count;
    logic                    empty, active, sel_m2, miss, wvalid_m, wlast_m, slv_rdy;
    logic                    is_last, fire, pop, push_ok;
    state_t                  state_q, state_d;
    logic [AXI_LEN_BITS-1:0] beat_q, beat_d;
    logic                    wdone_q, wdone_d, last_err_q, last_err_d;
    logic [1:0]              wdone_master_q, wdone_master_d;
    logic [2:0]              wdone_slave_q, wdone_slave_d;

    grant_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (aw_push),
        .pop     (pop),
        .wr_data ('{master: aw_master, slave: aw_slave, len: aw_len}),
        .rd_data (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (empty)
    );

    // head routing, beat counting, WLAST generation and next state
    always_comb begin
        active         = (state_q == ACTIVE) && !empty;
        sel_m2         = head.master == M2;
        miss           = head.slave >= 3'(NUM_SLAVES);
        wvalid_m       = sel_m2 ? WVALID_M2 : WVALID_M1;
        wlast_m        = sel_m2 ? WLAST_M2 : WLAST_M1;
        slv_rdy        = miss ? 1'b1 : WREADY_S[head.slave];
        is_last        = beat_q == head.len;
        fire           = active && wvalid_m && slv_rdy;
        pop            = fire && is_last;
        push_ok        = aw_push && !fifo_full;
        WDATA_S        = active ? (sel_m2 ? WDATA_M2 : WDATA_M1) : '0;
        WSTRB_S        = active ? (sel_m2 ? WSTRB_M2 : WSTRB_M1) : '0;
        WLAST_S        = active && is_last;
        WVALID_S       = (active && !miss && wvalid_m) ? NUM_SLAVES'(1) << head.slave : '0;
        WREADY_M1      = active && !sel_m2 && slv_rdy;
        WREADY_M2      = active && sel_m2 && slv_rdy;
        beat_d         = fire ? (is_last ? '0 : beat_q + 1'b1) : beat_q;
        wdone_d        = pop;
        wdone_master_d = head.master;
        wdone_slave_d  = head.slave;
        last_err_d     = fire && (wlast_m != is_last);
        state_d        = (state_q == IDLE) ? (push_ok ? ACTIVE : IDLE)
                       : ((pop && count == CW'(1) && !push_ok) ? IDLE : ACTIVE);
    end

    // state, beat counter and one-cycle completion/error pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            wdone_q        <= 1'b0;
            wdone_master_q <= '0;
            wdone_slave_q  <= '0;
            last_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            wdone_q        <= wdone_d;
            wdone_master_q <= wdone_master_d;
            wdone_slave_q  <= wdone_slave_d;
            last_err_q     <= last_err_d;
        end
    end

    assign wdone        = wdone_q;
    assign wdone_master = wdone_master_q;
    assign wdone_slave  = wdone_slave_q;
    assign last_err     = last_err_q;
endmodule

// File: tb/tb_write_data_router.sv
// tb_write_data_router: random and directed W-routing checks against a queue-based model
module tb_write_data_router;
    localparam int DEPTH = 2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aw_push;
    logic [1:0]  aw_master;
    logic [2:0]  aw_slave;
    logic [3:0]  aw_len;
    logic        fifo_full;
    logic [31:0] WDATA_M1, WDATA_M2, WDATA_S;
    logic [3:0]  WSTRB_M1, WSTRB_M2, WSTRB_S;
    logic        WLAST_M1, WLAST_M2, WVALID_M1, WVALID_M2, WREADY_M1, WREADY_M2, WLAST_S;
    logic [5:0]  WVALID_S, WREADY_S;
    logic        wdone, last_err;
    logic [1:0]  wdone_master;
    logic [2:0]  wdone_slave;

    int n_vec = 0;
    int n_err = 0;

    // model: outstanding grants and beats already accepted for the head
    int qm[$], qs[$], ql[$];
    int done_beats = 0;
    bit p_wdone = 0, p_lerr = 0;
    int p_m = 0, p_s = 0;

    write_data_router #(.DEPTH(DEPTH), .NUM_SLAVES(6)) dut (
        .clk(clk), .rst(rst), .aw_push(aw_push), .aw_master(aw_master), .aw_slave(aw_slave),
        .aw_len(aw_len), .fifo_full(fifo_full), .WDATA_M1(WDATA_M1), .WDATA_M2(WDATA_M2),
        .WSTRB_M1(WSTRB_M1), .WSTRB_M2(WSTRB_M2), .WLAST_M1(WLAST_M1), .WLAST_M2(WLAST_M2),
        .WVALID_M1(WVALID_M1), .WVALID_M2(WVALID_M2), .WREADY_M1(WREADY_M1), .WREADY_M2(WREADY_M2),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
        .WREADY_S(WREADY_S), .wdone(wdone), .wdone_master(wdone_master), .wdone_slave(wdone_slave),
        .last_err(last_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        aw_push = 0; aw_master = 0; aw_slave = 0; aw_len = 0;
        WDATA_M1 = 0; WDATA_M2 = 0; WSTRB_M1 = 0; WSTRB_M2 = 0;
        WLAST_M1 = 0; WLAST_M2 = 0; WVALID_M1 = 0; WVALID_M2 = 0; WREADY_S = 0;
    endtask

    task automatic aw(input int m, input int s, input int l);
        aw_push = 1; aw_master = 2'(m); aw_slave = 3'(s); aw_len = 4'(l);
    endtask

    // every falling edge: predict all outputs from the grant queue, compare, then advance the model
    always @(negedge clk) begin : cmp
        bit act, vm, wl, rdy, fire, full_before, nd;
        int m, s, len, nm, ns;
        logic [31:0] ed;
        logic [3:0]  es;
        logic [5:0]  evs;
        if (!rst) begin
            qm.delete(); qs.delete(); ql.delete();
            done_beats = 0; p_wdone = 0; p_lerr = 0;
        end
        act = qm.size() > 0;
        m   = act ? qm[0] : 0;
        s   = act ? qs[0] : 0;
        len = act ? ql[0] : 0;
        vm  = (m == 2) ? WVALID_M2 : WVALID_M1;
        wl  = (m == 2) ? WLAST_M2 : WLAST_M1;
        ed  = !act ? 32'h0 : (m == 2) ? WDATA_M2 : WDATA_M1;
        es  = !act ? 4'h0 : (m == 2) ? WSTRB_M2 : WSTRB_M1;
        rdy = act && ((s == 6) ? 1'b1 : WREADY_S[s % 6]);
        evs = (act && s < 6 && vm) ? (6'b1 << s) : 6'b0;
        chk("wdata_s", WDATA_S, ed);
        chk("wstrb_s", WSTRB_S, es);
        chk("wlast_s", WLAST_S, act && done_beats == len);
        chk("wvalid_s", WVALID_S, evs);
        chk("wready_m1", WREADY_M1, rdy && m == 1);
        chk("wready_m2", WREADY_M2, rdy && m == 2);
        chk("fifo_full", fifo_full, qm.size() == DEPTH);
        chk("wdone", wdone, p_wdone);
        chk("last_err", last_err, p_lerr);
        if (p_wdone) begin
            chk("wdone_master", wdone_master, 64'(p_m));
            chk("wdone_slave", wdone_slave, 64'(p_s));
        end
        chk("no_push_when_full", aw_push && fifo_full, 0);
        if (rst) begin
            fire = act && vm && rdy;
            full_before = qm.size() == DEPTH;
            p_lerr = fire && (wl != (done_beats == len));
            nd = 0; nm = 0; ns = 0;
            if (fire) begin
                if (done_beats == len) begin
                    nd = 1; nm = m; ns = s;
                    void'(qm.pop_front()); void'(qs.pop_front()); void'(ql.pop_front());
                    done_beats = 0;
                end else done_beats++;
            end
            if (aw_push && !full_before) begin
                qm.push_back(int'(aw_master)); qs.push_back(int'(aw_slave)); ql.push_back(int'(aw_len));
            end
            p_wdone = nd; p_m = nm; p_s = ns;
        end
    end

    initial begin
        clr();
        #1 rst = 0;
        @(negedge clk);
        chk("rst_wvalid_s", WVALID_S, 6'b0);
        chk("rst_wready_m1", WREADY_M1, 0);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_wdone", wdone, 0);
        nxt();
        rst = 1;
        // single beat to S2
        aw(1, 2, 0);
        nxt(); clr();
        WVALID_M1 = 1; WDATA_M1 = 32'hDEADBEEF; WSTRB_M1 = 4'hF; WREADY_S = 6'b000100; WLAST_M1 = 1;
        @(negedge clk);
        chk("sb_wvalid_s", WVALID_S, 6'b000100);
        chk("sb_wdata_s", WDATA_S, 32'hDEADBEEF);
        chk("sb_wlast_s", WLAST_S, 1);
        chk("sb_wready_m1", WREADY_M1, 1);
        nxt(); clr();
        @(negedge clk);
        chk("sb_wdone", wdone, 1);
        chk("sb_wdone_master", wdone_master, 1);
        chk("sb_wdone_slave", wdone_slave, 2);
        // fill the queue, then drain with M2 waiting behind M1's turn
        nxt(); aw(2, 4, 1);
        nxt(); aw(1, 3, 0);
        nxt(); clr();
        @(negedge clk);
        chk("full_set", fifo_full, 1);
        nxt(); WVALID_M2 = 1; WREADY_S = 6'b111111; WLAST_M2 = 1;
        nxt(); nxt();
        @(negedge clk);
        chk("full_clear", fifo_full, 0);
        chk("ord_wready_m2", WREADY_M2, 0);
        nxt(); clr(); WVALID_M1 = 1; WREADY_S = 6'b111111; WLAST_M1 = 1;
        nxt(); clr();
        nxt();
        // decode miss absorbs three beats
        aw(1, 6, 2);
        nxt(); clr(); WVALID_M1 = 1;
        for (int i = 0; i < 3; i++) begin
            WLAST_M1 = (i == 2);
            @(negedge clk);
            chk("miss_wvalid_s", WVALID_S, 6'b0);
            chk("miss_wready_m1", WREADY_M1, 1);
            nxt();
        end
        clr();
        @(negedge clk);
        chk("miss_wdone", wdone, 1);
        chk("miss_wdone_slave", wdone_slave, 6);
        // early master WLAST flags an error but the burst still runs its full length
        nxt(); aw(1, 0, 2);
        nxt(); clr(); WVALID_M1 = 1; WREADY_S = 6'b000001; WLAST_M1 = 1;
        nxt(); WLAST_M1 = 0;
        @(negedge clk);
        chk("err_last_err", last_err, 1);
        chk("err_no_early_done", wdone, 0);
        nxt(); WLAST_M1 = 1;
        nxt(); clr();
        @(negedge clk);
        chk("err_wdone", wdone, 1);
        // reset in the middle of a burst
        nxt(); aw(2, 4, 3);
        nxt(); clr(); WVALID_M2 = 1; WDATA_M2 = 32'h12345678; WREADY_S = 6'b010000;
        nxt(); rst = 0;
        @(negedge clk);
        chk("mid_rst_wvalid_s", WVALID_S, 6'b0);
        chk("mid_rst_wdata_s", WDATA_S, 32'h0);
        chk("mid_rst_wready_m2", WREADY_M2, 0);
        nxt(); rst = 1; clr();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_wdone", wdone, 0);
            nxt();
        end
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            aw_push   = !fifo_full && ($urandom_range(0, 3) == 0);
            aw_master = 2'($urandom_range(1, 2));
            aw_slave  = 3'($urandom_range(0, 6));
            aw_len    = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            WVALID_M1 = $urandom_range(0, 3) != 0;
            WVALID_M2 = $urandom_range(0, 3) != 0;
            WDATA_M1  = $urandom;
            WDATA_M2  = $urandom;
            WSTRB_M1  = 4'($urandom);
            WSTRB_M2  = 4'($urandom);
            WLAST_M1  = $urandom_range(0, 3) == 0;
            WLAST_M2  = $urandom_range(0, 3) == 0;
            WREADY_S  = 6'($urandom);
            nxt();
        end
        clr();
        nxt(); nxt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
